lampfpu_div_sched: RTL and testbench
====================================

// Module: lampfpu_div_sched
// PURPOSE
//  Shares one multi-cycle lampFPU divide path (prepare -> lampFPU_div -> round) between NREQ requesters.
//  Round-robin arbitration, one outstanding divide at a time, operand capture/hold, start pulse
//  (drives doDiv_i), completion wait with watchdog, single-entry buffered response with valid/ready.
// PARAMETERS
//  NREQ     2   number of requesters (>=2)
//  FP_W     16  raw operand/result width (bfloat16: 1 sign, 8 exp, 7 frac)
//  TAG_W    2   opaque requester tag, returned with result
//  TIMEOUT  31  max WAIT cycles for div_valid_i before error completion
// PORTS
//  clk           in   1            clock
//  rst           in   1            synchronous reset, active-high
//  req_valid_i   in   NREQ         request valid per requester
//  req_ready_o   out  NREQ         request accepted (one-hot or zero)
//  req_opa_i     in   NREQ*FP_W    dividend, requester r at [r*FP_W +: FP_W]
//  req_opb_i     in   NREQ*FP_W    divisor, same packing
//  req_tag_i     in   NREQ*TAG_W   tag, same packing
//  div_start_o   out  1            one-cycle start pulse to divide path (doDiv_i)
//  div_opa_o     out  FP_W         registered dividend, stable from ISSUE until IDLE
//  div_opb_o     out  FP_W         registered divisor, same
//  div_valid_i   in   1            divide path result valid (1-cycle pulse)
//  div_res_i     in   FP_W         rounded divide result
//  rsp_valid_o   out  1            response valid
//  rsp_ready_i   in   1            response consumed
//  rsp_id_o      out  $clog2(NREQ) index of granted requester
//  rsp_tag_o     out  TAG_W        tag captured at accept
//  rsp_res_o     out  FP_W         quotient, or 16'h7FC0 (qNaN) on timeout
//  rsp_err_o     out  1            1 = watchdog timeout completion
//  busy_o        out  1            state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=NREQ-1 (req0 wins first), all outputs 0, wdog=0.
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; exactly one state per cycle except WAIT/RESP.
//  IDLE: grant g = first r with req_valid_i[r], scanning from rr_ptr+1 modulo NREQ.
//   req_ready_o[g]=1 combinationally same cycle (only in IDLE); on handshake capture opa/opb/tag/id,
//   rr_ptr<=g, go ISSUE. No request -> stay IDLE, req_ready_o=0.
//  ISSUE: div_start_o=1 for exactly this cycle; wdog<=0; -> WAIT.
//  WAIT: wdog increments each cycle. div_valid_i=1 -> rsp_res<=div_res_i, err<=0, -> RESP.
//   else wdog==TIMEOUT -> rsp_res<=16'h7FC0, err<=1, -> RESP (TIMEOUT+1 WAIT cycles max).
//   div_valid_i has priority over timeout in the same cycle.
//  RESP: rsp_valid_o=1; id/tag/res/err held stable until rsp_ready_i=1; on handshake -> IDLE
//   (next grant evaluated in following cycle; no accept during RESP).
//  div_valid_i outside WAIT ignored (no state/output change).
//  Latency (zero-stall, div path latency L from start to valid): accept cycle t, start t+1,
//   div_valid t+1+L, rsp_valid_o t+2+L. Throughput: one divide per L+3 cycles min.
//  div_opa_o/div_opb_o change only on IDLE accept; they hold while downstream computes.
//  Reset mid-operation (any state): returns to IDLE next cycle, in-flight result discarded,
//   rr_ptr reinitialised; a late div_valid_i after reset ignored.
//  wdog width $clog2(TIMEOUT+1); never wraps (saturation impossible by FSM exit).
// TESTING
//  1 req0 opa=16'h4000(2.0) opb=16'h3F80(1.0), model L=10 res=16'h4000 -> start 1 cycle after
//    accept, rsp_valid 12 cycles after accept, id=0, res=16'h4000, err=0.
//  2 req0,req1 held valid continuously, rsp_ready_i=1 -> grants 0,1,0,1...; no double grant.
//  3 rsp_ready_i low 5 cycles in RESP -> rsp_* stable, req_ready_o=0, no start pulse; then IDLE.
//  4 model never returns valid -> rsp_valid with err=1, res=16'h7FC0 after 32 WAIT cycles.
//  5 rst pulsed in WAIT, model valid 3 cycles later -> no rsp_valid, busy_o=0, next grant req0.
//  6 div_valid_i pulse in IDLE and RESP -> ignored; div_valid_i with wdog==TIMEOUT -> err=0.

Source files
------------

// File: rtl/lampfpu_div_sched_if.sv
// Request / divide-path / response bundle for the shared lampFPU divide scheduler.
// master = requesters + divide path + response sink, slave = scheduler.
interface lampfpu_div_sched_if #(
  parameter int NREQ  = 2,
  parameter int FP_W  = 16,
  parameter int TAG_W = 2
);
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req_valid_i;
  logic [NREQ-1:0]       req_ready_o;
  logic [NREQ*FP_W-1:0]  req_opa_i;
  logic [NREQ*FP_W-1:0]  req_opb_i;
  logic [NREQ*TAG_W-1:0] req_tag_i;
  logic                  div_start_o;
  logic [FP_W-1:0]       div_opa_o;
  logic [FP_W-1:0]       div_opb_o;
  logic                  div_valid_i;
  logic [FP_W-1:0]       div_res_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [ID_W-1:0]       rsp_id_o;
  logic [TAG_W-1:0]      rsp_tag_o;
  logic [FP_W-1:0]       rsp_res_o;
  logic                  rsp_err_o;
  logic                  busy_o;

  modport master (
    output req_valid_i, req_opa_i, req_opb_i, req_tag_i, div_valid_i, div_res_i, rsp_ready_i,
    input  req_ready_o, div_start_o, div_opa_o, div_opb_o, rsp_valid_o, rsp_id_o, rsp_tag_o,
           rsp_res_o, rsp_err_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_opa_i, req_opb_i, req_tag_i, div_valid_i, div_res_i, rsp_ready_i,
    output req_ready_o, div_start_o, div_opa_o, div_opb_o, rsp_valid_o, rsp_id_o, rsp_tag_o,
           rsp_res_o, rsp_err_o, busy_o
  );
endinterface

// File: rtl/lampfpu_div_sched.sv
// Round-robin scheduler sharing one multi-cycle lampFPU divide path between NREQ requesters.
// Latency: accept t, start t+1, response valid one cycle after div_valid_i (or after watchdog).
// Backpressure: single-entry response held until rsp_ready_i; no new accept until it drains.
module lampfpu_div_sched #(
  parameter int NREQ    = 2,
  parameter int FP_W    = 16,
  parameter int TAG_W   = 2,
  parameter int TIMEOUT = 31
) (
  input  logic              clk,
  input  logic              rst,
  lampfpu_div_sched_if.slave io
);
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [FP_W-1:0] QNAN = FP_W'(16'h7FC0);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [FP_W-1:0]   opa_q, opa_d;
  logic [FP_W-1:0]   opb_q, opb_d;
  logic [FP_W-1:0]   res_q, res_d;
  logic              err_q, err_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;

  logic              gnt_vld;
  logic [ID_W-1:0]   gnt_idx;
  logic [FP_W-1:0]   sel_opa, sel_opb;
  logic [TAG_W-1:0]  sel_tag;
  logic [NREQ-1:0]   req_ready;

  // Scan downward so the requester closest after rr_ptr is the last (winning) assignment.
  always_comb begin
    logic [ID_W-1:0] idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = ID_W'((int'(rr_ptr_q) + i) % NREQ);
      if (io.req_valid_i[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  always_comb begin
    sel_opa = '0;
    sel_opb = '0;
    sel_tag = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (gnt_idx == ID_W'(r)) begin
        sel_opa = io.req_opa_i[r*FP_W +: FP_W];
        sel_opb = io.req_opb_i[r*FP_W +: FP_W];
        sel_tag = io.req_tag_i[r*TAG_W +: TAG_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    tag_d     = tag_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    res_d     = res_q;
    err_d     = err_q;
    wdog_d    = wdog_q;
    req_ready = '0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          req_ready[gnt_idx] = 1'b1;
          rr_ptr_d = gnt_idx;
          id_d     = gnt_idx;
          tag_d    = sel_tag;
          opa_d    = sel_opa;
          opb_d    = sel_opb;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wdog_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A result arriving on the last watchdog cycle still wins over the timeout.
        if (io.div_valid_i) begin
          res_d   = io.div_res_i;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (wdog_q == WD_W'(TIMEOUT)) begin
          res_d   = QNAN;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      ST_RESP: begin
        if (io.rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= ID_W'(NREQ - 1);
      id_q     <= '0;
      tag_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      tag_q    <= tag_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      res_q    <= res_d;
      err_q    <= err_d;
      wdog_q   <= wdog_d;
    end
  end

  assign io.req_ready_o = req_ready;
  assign io.div_start_o = (state_q == ST_ISSUE);
  assign io.div_opa_o   = opa_q;
  assign io.div_opb_o   = opb_q;
  assign io.rsp_valid_o = (state_q == ST_RESP);
  assign io.rsp_id_o    = id_q;
  assign io.rsp_tag_o   = tag_q;
  assign io.rsp_res_o   = res_q;
  assign io.rsp_err_o   = err_q;
  assign io.busy_o      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_lampfpu_div_sched.sv
// Directed bench for lampfpu_div_sched: behavioural divide path with programmable latency,
// scoreboard of expected responses filled at accept and drained at response handshake.
`timescale 1ns/1ps

module tb_lampfpu_div_sched;
  localparam int NREQ    = 2;
  localparam int FP_W    = 16;
  localparam int TAG_W   = 2;
  localparam int TIMEOUT = 31;

  typedef struct packed {
    logic [0:0]  id;
    logic [1:0]  tag;
    logic [15:0] res;
    logic        err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lampfpu_div_sched_if #(.NREQ(NREQ), .FP_W(FP_W), .TAG_W(TAG_W)) io ();

  lampfpu_div_sched #(.NREQ(NREQ), .FP_W(FP_W), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  rsp_t        sb[$];
  int          grants[$];
  int          cyc = 0;
  int          acc_cyc = -1;
  int          start_cyc = -1;
  int          rsp_cyc = -1;
  int          model_lat = 10;
  int          inj_cnt = 0;
  logic [15:0] inj_res = '0;
  logic [15:0] snap;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input bit ok, input logic [31:0] obs);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $error("FAIL %s: observed=%0h", tag, obs);
    end
  endtask

  // Stand-in for the divide path: exact for divide-by-one, an arbitrary mix otherwise.
  function automatic logic [15:0] div_fn(input logic [15:0] a, input logic [15:0] b);
    return (b == 16'h3F80) ? a : (a ^ b);
  endfunction

  initial begin : div_model
    int          cnt = 0;
    int          seen = 0;
    logic [15:0] res = '0;
    io.div_valid_i = 1'b0;
    io.div_res_i   = '0;
    forever begin
      @(posedge clk);
      #2;
      io.div_valid_i = 1'b0;
      if (seen != inj_cnt) begin
        seen           = inj_cnt;
        io.div_valid_i = 1'b1;
        io.div_res_i   = inj_res;
      end else if (cnt == 1) begin
        io.div_valid_i = 1'b1;
        io.div_res_i   = res;
        cnt            = 0;
      end else if (cnt > 1) begin
        cnt--;
      end
      if (io.div_start_o && model_lat > 0) begin
        res = div_fn(io.div_opa_o, io.div_opb_o);
        cnt = model_lat;
      end
    end
  end

  initial begin : monitor
    rsp_t e;
    logic prev_rsp = 1'b0;
    forever begin
      @(negedge clk);
      #3;
      if (!rst) begin
        if (io.req_ready_o != '0) begin
          chk("ready_onehot", $countones(io.req_ready_o) <= 1, io.req_ready_o);
          chk("ready_needs_valid", (io.req_ready_o & ~io.req_valid_i) === 2'b00, io.req_ready_o);
        end
        for (int r = 0; r < NREQ; r++) begin
          if (io.req_valid_i[r] && io.req_ready_o[r]) begin
            e.id  = 1'(r);
            e.tag = io.req_tag_i[r*TAG_W +: TAG_W];
            e.err = (model_lat == 0 || model_lat > TIMEOUT + 1);
            e.res = e.err ? 16'h7FC0 : div_fn(io.req_opa_i[r*FP_W +: FP_W], io.req_opb_i[r*FP_W +: FP_W]);
            sb.push_back(e);
            grants.push_back(r);
            acc_cyc = cyc;
          end
        end
        if (io.div_start_o) start_cyc = cyc;
        if (io.rsp_valid_o && !prev_rsp) rsp_cyc = cyc;
        if (io.rsp_valid_o && io.rsp_ready_i) begin
          chk("rsp_expected", sb.size() > 0, sb.size());
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_id", io.rsp_id_o === e.id, io.rsp_id_o);
            chk("sb_tag", io.rsp_tag_o === e.tag, io.rsp_tag_o);
            chk("sb_res", io.rsp_res_o === e.res, io.rsp_res_o);
            chk("sb_err", io.rsp_err_o === e.err, io.rsp_err_o);
          end
        end
      end
      prev_rsp = io.rsp_valid_o;
    end
  end

  initial begin : global_watchdog
    #200000;
    $display("FAIL global_timeout: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "global timeout");
  end

  task automatic set_req(input int r, input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] t);
    io.req_valid_i[r]                = v;
    io.req_opa_i[r*FP_W +: FP_W]     = a;
    io.req_opb_i[r*FP_W +: FP_W]     = b;
    io.req_tag_i[r*TAG_W +: TAG_W]   = t;
  endtask

  task automatic issue(input int r, input logic [15:0] a, input logic [15:0] b, input logic [1:0] t);
    logic hs = 1'b0;
    @(negedge clk);
    set_req(r, 1'b1, a, b, t);
    for (int k = 0; k < 200 && !hs; k++) begin
      #1;
      hs = io.req_ready_o[r];
      @(negedge clk);
    end
    chk("accept_seen", hs === 1'b1, hs);
    io.req_valid_i[r] = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int k = 0;
    while (!io.rsp_valid_o && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk(tag, io.rsp_valid_o === 1'b1, io.rsp_valid_o);
    #4;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    @(negedge clk);
    while (io.busy_o && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk(tag, io.busy_o === 1'b0, io.busy_o);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : main
    rst            = 1'b1;
    io.req_valid_i = '0;
    io.req_opa_i   = '0;
    io.req_opb_i   = '0;
    io.req_tag_i   = '0;
    io.rsp_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", io.busy_o === 1'b0, io.busy_o);
    chk("rst_rsp_valid", io.rsp_valid_o === 1'b0, io.rsp_valid_o);
    chk("rst_start", io.div_start_o === 1'b0, io.div_start_o);
    chk("rst_req_ready", io.req_ready_o === 2'b00, io.req_ready_o);
    chk("rst_rsp_res", io.rsp_res_o === 16'h0000, io.rsp_res_o);
    chk("rst_rsp_err", io.rsp_err_o === 1'b0, io.rsp_err_o);
    chk("rst_div_opa", io.div_opa_o === 16'h0000, io.div_opa_o);
    rst = 1'b0;

    // Single divide 2.0 / 1.0 with a 10-cycle divide path.
    model_lat = 10;
    issue(0, 16'h4000, 16'h3F80, 2'd1);
    wait_rsp("t1_rsp_seen");
    chk("t1_start_lat", (start_cyc - acc_cyc) == 1, start_cyc - acc_cyc);
    chk("t1_rsp_lat", (rsp_cyc - acc_cyc) == 12, rsp_cyc - acc_cyc);
    chk("t1_res", io.rsp_res_o === 16'h4000, io.rsp_res_o);
    chk("t1_err", io.rsp_err_o === 1'b0, io.rsp_err_o);
    chk("t1_id", io.rsp_id_o === 1'b0, io.rsp_id_o);
    wait_idle("t1_idle");

    // Both requesters held valid: strict alternation starting at req0 after reset.
    do_reset();
    model_lat = 3;
    grants.delete();
    @(negedge clk);
    set_req(0, 1'b1, 16'h4040, 16'h4000, 2'd2);
    set_req(1, 1'b1, 16'h3F80, 16'h4080, 2'd3);
    for (int k = 0; k < 400 && grants.size() < 6; k++) @(negedge clk);
    io.req_valid_i = '0;
    chk("t2_grant_count", grants.size() == 6, grants.size());
    for (int i = 0; i < grants.size() && i < 6; i++)
      chk("t2_grant_order", grants[i] == (i % 2), grants[i]);
    wait_idle("t2_idle");

    // Response stalled 5 cycles with a competing request and a stray div_valid pulse.
    model_lat = 4;
    io.rsp_ready_i = 1'b0;
    issue(1, 16'h4100, 16'h4000, 2'd2);
    set_req(0, 1'b1, 16'h4200, 16'h3F80, 2'd0);
    wait_rsp("t3_rsp_seen");
    snap = io.rsp_res_o;
    chk("t3_res", snap === 16'h0100, snap);
    inj_res = 16'hDEAD;
    inj_cnt++;
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("t3_hold_valid", io.rsp_valid_o === 1'b1, io.rsp_valid_o);
      chk("t3_hold_res", io.rsp_res_o === 16'h0100, io.rsp_res_o);
      chk("t3_hold_id", io.rsp_id_o === 1'b1, io.rsp_id_o);
      chk("t3_hold_tag", io.rsp_tag_o === 2'd2, io.rsp_tag_o);
      chk("t3_hold_err", io.rsp_err_o === 1'b0, io.rsp_err_o);
      chk("t3_no_ready", io.req_ready_o === 2'b00, io.req_ready_o);
      chk("t3_no_start", io.div_start_o === 1'b0, io.div_start_o);
    end
    io.req_valid_i = '0;
    io.rsp_ready_i = 1'b1;
    @(negedge clk);
    #1;
    chk("t3_back_idle", io.busy_o === 1'b0, io.busy_o);
    chk("t3_rsp_dropped", io.rsp_valid_o === 1'b0, io.rsp_valid_o);

    // Stray div_valid pulse while idle.
    inj_res = 16'hBEEF;
    inj_cnt++;
    repeat (4) @(negedge clk);
    #1;
    chk("t6_idle_busy", io.busy_o === 1'b0, io.busy_o);
    chk("t6_idle_rsp", io.rsp_valid_o === 1'b0, io.rsp_valid_o);

    // Divide path never answers: watchdog completion after 32 WAIT cycles.
    model_lat = 0;
    issue(0, 16'h4000, 16'h4000, 2'd1);
    wait_rsp("t4_rsp_seen");
    chk("t4_rsp_lat", (rsp_cyc - acc_cyc) == 34, rsp_cyc - acc_cyc);
    chk("t4_err", io.rsp_err_o === 1'b1, io.rsp_err_o);
    chk("t4_res", io.rsp_res_o === 16'h7FC0, io.rsp_res_o);
    wait_idle("t4_idle");

    // Result on the final watchdog cycle wins; one cycle later it is a timeout.
    model_lat = 32;
    issue(1, 16'h4000, 16'h4080, 2'd3);
    wait_rsp("t6_edge_seen");
    chk("t6_edge_lat", (rsp_cyc - acc_cyc) == 34, rsp_cyc - acc_cyc);
    chk("t6_edge_err", io.rsp_err_o === 1'b0, io.rsp_err_o);
    chk("t6_edge_res", io.rsp_res_o === 16'h0080, io.rsp_res_o);
    wait_idle("t6_edge_idle");
    model_lat = 33;
    issue(1, 16'h4000, 16'h4080, 2'd0);
    wait_rsp("t6_late_seen");
    chk("t6_late_err", io.rsp_err_o === 1'b1, io.rsp_err_o);
    wait_idle("t6_late_idle");

    // Reset during WAIT: result discarded, late div_valid ignored, rr pointer reinitialised.
    model_lat = 5;
    issue(0, 16'h4000, 16'h3F80, 2'd0);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      #1;
      chk("t5_no_rsp", io.rsp_valid_o === 1'b0, io.rsp_valid_o);
      chk("t5_not_busy", io.busy_o === 1'b0, io.busy_o);
    end
    set_req(0, 1'b1, 16'h4000, 16'h3F80, 2'd1);
    set_req(1, 1'b1, 16'h4100, 16'h3F80, 2'd2);
    #1;
    chk("t5_grant_req0", io.req_ready_o === 2'b01, io.req_ready_o);
    @(negedge clk);
    io.req_valid_i = '0;
    wait_rsp("t5_rsp_seen");
    chk("t5_id", io.rsp_id_o === 1'b0, io.rsp_id_o);
    wait_idle("t5_idle");

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size() == 0, sb.size());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
